dispatch_ctrl: RTL and testbench

//  Sequences the instruction decoder: buffers fetched instructions in an instruction queue and

---
 rtl/dispatch_ctrl_pkg.sv | 52 +++++
 rtl/dispatch_ctrl_if.sv | 41 ++++
 rtl/dispatch_ctrl_inst_queue.sv | 71 +++++++
 rtl/dispatch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dispatch_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_ctrl_pkg.sv
// Shared definitions for the dispatch controller: decoder op_type codes,
// the register-unused encoding, FSM states, queue/dispatch records and
// a saturating counter helper.
// Optional feature macro: DISPATCH_PERF_EN (performance counters).
package dispatch_ctrl_pkg;

  // Decoder op_type codes; 0 marks an illegal instruction.
  typedef enum logic [2:0] {
    OPT_ILLEGAL = 3'd0,
    RType       = 3'd1,
    IType       = 3'd2,
    ILoadType   = 3'd3,
    SType       = 3'd4,
    BType       = 3'd5,
    UType       = 3'd6,
    JType       = 3'd7
  } op_type_e;

  // Register field value meaning "operand not used".
  localparam logic [5:0] REG_NULL = 6'd32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } dis_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [2:0]  typ;
    logic [31:0] imm;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rd;
    logic [31:0] pc;
  } dis_pkt_t;

  // Loads and stores go to the load/store buffer, everything else to the RS.
  function automatic logic routes_to_lsb(input logic [2:0] t);
    return (t == ILoadType) || (t == SType);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Fetch-side and dispatch-side bus of the dispatch controller.
// master: the dispatch controller; slave: ifetch plus RS/LSB/ROB side.
interface dispatch_ctrl_if;
  logic        if_valid_in;
  logic [31:0] if_inst_in;
  logic [31:0] if_pc_in;
  logic        iq_full_out;

  logic        rob_full_in;
  logic        rs_full_in;
  logic        lsb_full_in;

  logic        rob_valid_out;
  logic        rs_valid_out;
  logic        lsb_valid_out;
  logic [5:0]  dis_op_out;
  logic [2:0]  dis_type_out;
  logic [31:0] dis_imm_out;
  logic [5:0]  dis_rs1_out;
  logic [5:0]  dis_rs2_out;
  logic [5:0]  dis_rd_out;
  logic [31:0] dis_pc_out;

  modport master (
    input  if_valid_in, if_inst_in, if_pc_in,
    input  rob_full_in, rs_full_in, lsb_full_in,
    output iq_full_out,
    output rob_valid_out, rs_valid_out, lsb_valid_out,
    output dis_op_out, dis_type_out, dis_imm_out,
    output dis_rs1_out, dis_rs2_out, dis_rd_out, dis_pc_out
  );

  modport slave (
    output if_valid_in, if_inst_in, if_pc_in,
    output rob_full_in, rs_full_in, lsb_full_in,
    input  iq_full_out,
    input  rob_valid_out, rs_valid_out, lsb_valid_out,
    input  dis_op_out, dis_type_out, dis_imm_out,
    input  dis_rs1_out, dis_rs2_out, dis_rd_out, dis_pc_out
  );
endinterface

// File: rtl/dispatch_ctrl_inst_queue.sv
// Circular instruction queue of {pc, inst} entries with push/pop/clear.
// Clear has priority over push and pop; the head entry is always shown
// (the consumer qualifies it with empty_o).
module dispatch_ctrl_inst_queue
  import dispatch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  logic      pop_i,
  input  logic      clear_i,
  input  iq_entry_t data_i,
  output iq_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  iq_entry_t         mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A full queue never accepts a push, even if the head leaves this cycle.
  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;

  // Next pointer/count values; pointers wrap naturally at the depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      count_d = count_q + (ADDR_W + 1)'(do_push) - (ADDR_W + 1)'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless outside the valid window.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: buffers fetched instructions, shows the queue head
// to the external decoder and routes each decoded op to the RS or LSB
// together with a ROB entry, honouring per-unit full back-pressure.
// Optional feature macro: DISPATCH_PERF_EN adds perf_dis_out and
// perf_stall_out saturating event counters.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int IQ_ADDR_W = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  output logic [31:0] dec_inst_out,
  input  logic [5:0]  dec_op_in,
  input  logic [2:0]  dec_type_in,
  input  logic [31:0] dec_imm_in,
  input  logic [5:0]  dec_rs1_in,
  input  logic [5:0]  dec_rs2_in,
  input  logic [5:0]  dec_rd_in,
`ifdef DISPATCH_PERF_EN
  output logic [31:0] perf_dis_out,
  output logic [31:0] perf_stall_out,
`endif
  dispatch_ctrl_if.master bus
);

  dis_state_e state_q, state_d;
  dis_pkt_t   pkt_q, pkt_d;
  logic       rob_vld_q, rob_vld_d;
  logic       rs_vld_q, rs_vld_d;
  logic       lsb_vld_q, lsb_vld_d;

  iq_entry_t  iq_head;
  logic       iq_full, iq_empty;
  logic       enq, head_live, is_illegal, to_lsb, unit_full;
  logic       dispatch, drop, blocked;

  dispatch_ctrl_inst_queue #(
    .ADDR_W (IQ_ADDR_W)
  ) u_iq (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .push_i  (enq),
    .pop_i   (dispatch || drop),
    .clear_i (clear_in),
    .data_i  ('{pc: bus.if_pc_in, inst: bus.if_inst_in}),
    .head_o  (iq_head),
    .full_o  (iq_full),
    .empty_o (iq_empty)
  );

  assign bus.iq_full_out = iq_full;
  assign dec_inst_out    = iq_empty ? 32'd0 : iq_head.inst;

  // Fetch keeps filling the queue while the head is stalled; only the
  // one-cycle FLUSH window (and a same-cycle clear) drops fetched words.
  assign enq = rdy_in && bus.if_valid_in && !iq_full && (state_q != FLUSH) && !clear_in;

  assign head_live  = !iq_empty && rdy_in && !clear_in;
  assign is_illegal = (dec_type_in == OPT_ILLEGAL);
  assign to_lsb     = routes_to_lsb(dec_type_in);
  assign unit_full  = bus.rob_full_in || (to_lsb ? bus.lsb_full_in : bus.rs_full_in);
  assign drop       = head_live && is_illegal;
  assign dispatch   = head_live && !is_illegal && !unit_full;
  assign blocked    = head_live && !is_illegal && unit_full;

  // Next-state logic: clear always flushes, otherwise track head blocking.
  always_comb begin
    state_d = state_q;
    if (clear_in) begin
      state_d = FLUSH;
    end else if (rdy_in) begin
      case (state_q)
        RUN:     if (blocked) state_d = STALL;
        STALL:   if (!blocked) state_d = RUN;
        FLUSH:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= RUN;
    else         state_q <= state_d;
  end

  // Strobe and payload next values; strobes last exactly one cycle.
  always_comb begin
    pkt_d     = pkt_q;
    rob_vld_d = rob_vld_q;
    rs_vld_d  = rs_vld_q;
    lsb_vld_d = lsb_vld_q;
    if (clear_in) begin
      rob_vld_d = 1'b0;
      rs_vld_d  = 1'b0;
      lsb_vld_d = 1'b0;
    end else if (rdy_in) begin
      rob_vld_d = dispatch;
      rs_vld_d  = dispatch && !to_lsb;
      lsb_vld_d = dispatch && to_lsb;
      if (dispatch) begin
        pkt_d = '{op:  dec_op_in,  typ: dec_type_in, imm: dec_imm_in,
                  rs1: dec_rs1_in, rs2: dec_rs2_in,  rd:  dec_rd_in,
                  pc:  iq_head.pc};
      end
    end
  end

  // Dispatch strobe and payload registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pkt_q     <= '0;
      rob_vld_q <= 1'b0;
      rs_vld_q  <= 1'b0;
      lsb_vld_q <= 1'b0;
    end else begin
      pkt_q     <= pkt_d;
      rob_vld_q <= rob_vld_d;
      rs_vld_q  <= rs_vld_d;
      lsb_vld_q <= lsb_vld_d;
    end
  end

  assign bus.rob_valid_out = rob_vld_q;
  assign bus.rs_valid_out  = rs_vld_q;
  assign bus.lsb_valid_out = lsb_vld_q;
  assign bus.dis_op_out    = pkt_q.op;
  assign bus.dis_type_out  = pkt_q.typ;
  assign bus.dis_imm_out   = pkt_q.imm;
  assign bus.dis_rs1_out   = pkt_q.rs1;
  assign bus.dis_rs2_out   = pkt_q.rs2;
  assign bus.dis_rd_out    = pkt_q.rd;
  assign bus.dis_pc_out    = pkt_q.pc;

`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_dis_q, perf_dis_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Counter increments; a flush does not reset the statistics.
  always_comb begin
    perf_dis_d   = perf_dis_q;
    perf_stall_d = perf_stall_q;
    if (dispatch)                     perf_dis_d   = sat_inc32(perf_dis_q);
    if (rdy_in && (state_q == STALL)) perf_stall_d = sat_inc32(perf_stall_q);
  end

  // Counter registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      perf_dis_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_dis_q   <= perf_dis_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_dis_out   = perf_dis_q;
  assign perf_stall_out = perf_stall_q;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Scoreboard bench for dispatch_ctrl: directed instructions push their
// hand-computed dispatch records; a negedge monitor pops and compares
// whenever a dispatch strobe is seen. The bench also plays the decoder.
`timescale 1ns/1ps
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        clear_in = 1'b0;
  logic [31:0] dec_inst_out;
  logic [5:0]  dec_op_in;
  logic [2:0]  dec_type_in;
  logic [31:0] dec_imm_in;
  logic [5:0]  dec_rs1_in, dec_rs2_in, dec_rd_in;
`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_dis_out, perf_stall_out;
`endif

  dispatch_ctrl_if bus();

  dispatch_ctrl #(.IQ_ADDR_W(3)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear_in     (clear_in),
    .dec_inst_out (dec_inst_out),
    .dec_op_in    (dec_op_in),
    .dec_type_in  (dec_type_in),
    .dec_imm_in   (dec_imm_in),
    .dec_rs1_in   (dec_rs1_in),
    .dec_rs2_in   (dec_rs2_in),
    .dec_rd_in    (dec_rd_in),
`ifdef DISPATCH_PERF_EN
    .perf_dis_out   (perf_dis_out),
    .perf_stall_out (perf_stall_out),
`endif
    .bus          (bus)
  );

  always #5 clk_in = ~clk_in;

  // Minimal decoder for the instructions used here (I-ALU, load, store).
  always_comb begin
    dec_op_in   = {dec_inst_out[14:12], dec_inst_out[6:4]};
    dec_type_in = OPT_ILLEGAL;
    dec_imm_in  = 32'd0;
    dec_rs1_in  = REG_NULL;
    dec_rs2_in  = REG_NULL;
    dec_rd_in   = REG_NULL;
    case (dec_inst_out[6:0])
      7'b0010011, 7'b0000011: begin
        dec_type_in = (dec_inst_out[6:0] == 7'b0000011) ? ILoadType : IType;
        dec_imm_in  = {{20{dec_inst_out[31]}}, dec_inst_out[31:20]};
        dec_rs1_in  = {1'b0, dec_inst_out[19:15]};
        dec_rd_in   = {1'b0, dec_inst_out[11:7]};
      end
      7'b0100011: begin
        dec_type_in = SType;
        dec_imm_in  = {{20{dec_inst_out[31]}}, dec_inst_out[31:25], dec_inst_out[11:7]};
        dec_rs1_in  = {1'b0, dec_inst_out[19:15]};
        dec_rs2_in  = {1'b0, dec_inst_out[24:20]};
      end
      default: ;
    endcase
  end

  typedef struct {
    logic        lsb;
    logic [2:0]  typ;
    logic [31:0] imm;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rd;
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int strobes = 0;
  int cyc = 0;
  int n_exp = 0;
  int last_strobe_cyc = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest expected dispatch.
  always @(negedge clk_in) begin : mon
    exp_t e;
    if (rst_in && (bus.rob_valid_out || bus.rs_valid_out || bus.lsb_valid_out)) begin
      strobes++;
      last_strobe_cyc = cyc;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL dispatch_unexpected: rob=%b rs=%b lsb=%b pc=%h, required no strobe",
                 bus.rob_valid_out, bus.rs_valid_out, bus.lsb_valid_out, bus.dis_pc_out);
      end else begin
        e = exp_q.pop_front();
        if (!(bus.rob_valid_out && (bus.rs_valid_out == !e.lsb) && (bus.lsb_valid_out == e.lsb) &&
              bus.dis_type_out == e.typ && bus.dis_imm_out == e.imm && bus.dis_rs1_out == e.rs1 &&
              bus.dis_rs2_out == e.rs2 && bus.dis_rd_out == e.rd && bus.dis_pc_out == e.pc)) begin
          fails++;
          $display("FAIL dispatch_pc%h: got rob=%b rs=%b lsb=%b type=%0d imm=%h rs1=%0d rs2=%0d rd=%0d pc=%h; required rob=1 lsb=%b type=%0d imm=%h rs1=%0d rs2=%0d rd=%0d pc=%h",
                   e.pc, bus.rob_valid_out, bus.rs_valid_out, bus.lsb_valid_out, bus.dis_type_out,
                   bus.dis_imm_out, bus.dis_rs1_out, bus.dis_rs2_out, bus.dis_rd_out, bus.dis_pc_out,
                   e.lsb, e.typ, e.imm, e.rs1, e.rs2, e.rd, e.pc);
        end
        if (e.cyc != 0) begin
          tests++;
          if (cyc != e.cyc) begin
            fails++;
            $display("FAIL latency_pc%h: strobe at cycle %0d, required cycle %0d", e.pc, cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_dis(input logic lsb, input logic [2:0] typ, input logic [31:0] imm,
                            input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rd,
                            input logic [31:0] pc, input int c);
    exp_t e;
    e.lsb = lsb; e.typ = typ; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.pc = pc; e.cyc = c;
    exp_q.push_back(e);
    n_exp++;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    bus.if_valid_in = 1'b1;
    bus.if_inst_in  = inst;
    bus.if_pc_in    = pc;
    tick();
    bus.if_valid_in = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
    tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] addi(input int rd, input int imm);
    return {12'(imm), 5'd0, 3'd0, 5'(rd), 7'h13};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int r0;
    bus.if_valid_in = 1'b0; bus.if_inst_in = '0; bus.if_pc_in = '0;
    bus.rob_full_in = 1'b0; bus.rs_full_in = 1'b0; bus.lsb_full_in = 1'b0;
    #2 rst_in = 1'b0;
    tick(); tick();
    check("rst_iq_full", 32'(bus.iq_full_out), 32'd0);
    check("rst_dec_inst", dec_inst_out, 32'd0);
    check("rst_strobes", 32'({bus.rob_valid_out, bus.rs_valid_out, bus.lsb_valid_out}), 32'd0);
    check("rst_payload", bus.dis_imm_out | bus.dis_pc_out | 32'(bus.dis_rd_out), 32'd0);
    rst_in = 1'b1;
    tick();

    // addi x1,x0,5 -> RS, two cycles after fetch
    expect_dis(1'b0, IType, 32'd5, 6'd0, REG_NULL, 6'd1, 32'h0, cyc + 2);
    issue(32'h00500093, 32'h0);
    check("head_visible", dec_inst_out, 32'h00500093);
    drain(10);

    // lw x2,4(x1) held by a full LSB for three cycles
    bus.lsb_full_in = 1'b1;
    s0 = strobes;
    expect_dis(1'b1, ILoadType, 32'd4, 6'd1, REG_NULL, 6'd2, 32'h4, 0);
    issue(32'h0040A103, 32'h4);
    repeat (3) tick();
    check("stall_no_strobe", 32'(strobes - s0), 32'd0);
    bus.lsb_full_in = 1'b0;
    drain(10);
    check("lsb_single_pulse", 32'(strobes - s0), 32'd1);
`ifdef DISPATCH_PERF_EN
    check("perf_stall", perf_stall_out, 32'd3);
`endif

    // sw x2,8(x1) goes to the LSB even while the RS is full
    bus.rs_full_in = 1'b1;
    expect_dis(1'b1, SType, 32'd8, 6'd1, 6'd2, REG_NULL, 32'h8, cyc + 2);
    issue(32'h0020A423, 32'h8);
    drain(10);
    bus.rs_full_in = 1'b0;

    // fill the queue behind a full ROB
    bus.rob_full_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("fill_not_full", 32'(bus.iq_full_out), 32'd0);
      expect_dis(1'b0, IType, 32'(i), 6'd0, REG_NULL, 6'd3, 32'h100 + 32'(4 * i), 0);
      issue(addi(3, i), 32'h100 + 32'(4 * i));
    end
    check("iq_full_after_8", 32'(bus.iq_full_out), 32'd1);
    bus.if_valid_in = 1'b1; bus.if_inst_in = addi(4, 99); bus.if_pc_in = 32'h200;
    tick();
    check("iq_full_hold", 32'(bus.iq_full_out), 32'd1);
    s0 = strobes;
    r0 = cyc;
    bus.rob_full_in = 1'b0;
    tick();
    bus.if_valid_in = 1'b0;
    check("iq_full_released", 32'(bus.iq_full_out), 32'd0);
    drain(20);
    check("fill_dispatch_count", 32'(strobes - s0), 32'd8);
    check("back_to_back", 32'(last_strobe_cyc - r0), 32'd8);

    // flush with 5 queued, fetch during clear and FLUSH ignored
    bus.rob_full_in = 1'b1;
    for (int i = 0; i < 5; i++) issue(addi(8, i + 1), 32'h280 + 32'(4 * i));
    check("pre_clear_head", dec_inst_out, addi(8, 1));
    s0 = strobes;
    clear_in = 1'b1;
    bus.rob_full_in = 1'b0;
    bus.if_valid_in = 1'b1; bus.if_inst_in = addi(9, 1); bus.if_pc_in = 32'h2F0;
    tick();
    clear_in = 1'b0;
    check("clear_empties", dec_inst_out, 32'd0);
    bus.if_inst_in = addi(5, 7); bus.if_pc_in = 32'h300;
    tick();
    check("flush_ignores_fetch", dec_inst_out, 32'd0);
    check("clear_no_strobe", 32'(strobes - s0), 32'd0);
    expect_dis(1'b0, IType, 32'd9, 6'd0, REG_NULL, 6'd6, 32'h304, cyc + 2);
    issue(addi(6, 9), 32'h304);
    drain(10);
    check("after_flush_count", 32'(strobes - s0), 32'd1);

    // illegal word dropped silently, following addi dispatched
    s0 = strobes;
    issue(32'hFFFF_FFFF, 32'h400);
    expect_dis(1'b0, IType, 32'd3, 6'd0, REG_NULL, 6'd7, 32'h404, cyc + 2);
    issue(addi(7, 3), 32'h404);
    drain(10);
    check("illegal_dropped", 32'(strobes - s0), 32'd1);
`ifdef DISPATCH_PERF_EN
    check("perf_dis", perf_dis_out, 32'(n_exp));
`endif

    // rdy_in low: fetch not accepted
    rdy_in = 1'b0;
    s0 = strobes;
    bus.if_valid_in = 1'b1; bus.if_inst_in = addi(10, 1); bus.if_pc_in = 32'h500;
    tick(); tick();
    bus.if_valid_in = 1'b0;
    check("rdy_low_no_enq", dec_inst_out, 32'd0);
    rdy_in = 1'b1;
    repeat (3) tick();
    check("rdy_low_no_strobe", 32'(strobes - s0), 32'd0);

    // reset mid-stream discards the queue
    bus.rob_full_in = 1'b1;
    issue(addi(11, 2), 32'h600);
    issue(addi(12, 3), 32'h604);
    check("pre_reset_head", dec_inst_out, addi(11, 2));
    s0 = strobes;
    rst_in = 1'b0;
    #1;
    check("midrst_dec_inst", dec_inst_out, 32'd0);
    check("midrst_iq_full", 32'(bus.iq_full_out), 32'd0);
    check("midrst_strobes", 32'({bus.rob_valid_out, bus.rs_valid_out, bus.lsb_valid_out}), 32'd0);
    bus.rob_full_in = 1'b0;
    tick();
    rst_in = 1'b1;
    repeat (4) tick();
    check("post_reset_no_dispatch", 32'(strobes - s0), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
